// File: rtl/grad_mag_l1.sv
// Pairs each buffered Dy sample with the matching Dx sample and emits the saturated
// L1 gradient magnitude |Dx|+|Dy| per pixel in raster order, with frame max and done pulse.
module grad_mag_l1 #(
    parameter int WIDTH   = 32,
    parameter int ADD_W   = 12,
    parameter int FIFO_AW = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_datay,
    input  logic             i_DyValid,
    input  logic [WIDTH-1:0] i_datax,
    input  logic             i_DxValid,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_valid,
    output logic [ADD_W-1:0] o_addr,
    output logic [WIDTH-1:0] o_max,
    output logic             o_done,
    output logic             o_bussy,
    output logic             o_err
);
    localparam int DEPTH = 2**FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic               flush_second_reg;
    logic [WIDTH-1:0]   mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [ADD_W-1:0]   pix_cnt_reg;
    logic               v1_reg;
    logic [WIDTH-1:0]   dy_rd_reg, adx_reg;
    logic [ADD_W-1:0]   addr1_reg;

    logic run, empty, full, pop, push, overflow, underflow, frame_start, last_pix;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   mag_sat;

    // Two's-complement magnitude; the most negative value maps exactly to 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    always_comb begin
        run         = (state_reg == S_RUN);
        empty       = (count_reg == '0);
        full        = count_reg[FIFO_AW];
        pop         = run && i_DxValid && !empty;
        push        = run && i_DyValid && (!full || pop);
        overflow    = run && i_DyValid && full && !pop;
        underflow   = run && i_DxValid && empty;
        frame_start = (state_reg == S_IDLE) && i_start;
        last_pix    = (pix_cnt_reg == '1);
        sum         = {1'b0, abs_val(dy_rd_reg)} + {1'b0, adx_reg};
        mag_sat     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (i_start) state_next = S_RUN;
            S_RUN:   if (pop && last_pix) state_next = S_FLUSH;
            S_FLUSH: if (flush_second_reg) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign o_done  = (state_reg == S_DONE);
    assign o_bussy = (state_reg == S_RUN) || (state_reg == S_FLUSH);

    // Buffer storage and its registered read port carry no reset so they map to block RAM;
    // validity is tracked by count_reg and v1_reg, which are reset.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_reg] <= i_datay;
        if (pop)  dy_rd_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg        <= S_IDLE;
            flush_second_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            pix_cnt_reg      <= '0;
            v1_reg           <= 1'b0;
            adx_reg          <= '0;
            addr1_reg        <= '0;
            o_valid          <= 1'b0;
            o_mag            <= '0;
            o_addr           <= '0;
            o_max            <= '0;
            o_err            <= 1'b0;
        end else begin
            state_reg        <= state_next;
            flush_second_reg <= (state_reg == S_FLUSH);
            if (frame_start) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                pix_cnt_reg <= '0;
                o_max       <= '0;
                o_err       <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + FIFO_AW'(1);
                    pix_cnt_reg <= pix_cnt_reg + ADD_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
                    2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
                    default: count_reg <= count_reg;
                endcase
                if (overflow || underflow) o_err <= 1'b1;
                if (v1_reg && (mag_sat > o_max)) o_max <= mag_sat;
            end
            // Stage 1: Dy read from buffer, |Dx| and pixel address captured alongside.
            v1_reg    <= pop;
            adx_reg   <= abs_val(i_datax);
            addr1_reg <= pix_cnt_reg;
            // Stage 2: saturated sum.
            o_valid   <= v1_reg;
            if (v1_reg) begin
                o_mag  <= mag_sat;
                o_addr <= addr1_reg;
            end
        end
    end
endmodule

// File: tb/tb_grad_mag_l1.sv
// Scoreboard bench for grad_mag_l1: a behavioural FIFO/pairing model predicts each result
// when Dx is driven; a monitor pops and compares whenever the DUT asserts o_valid.
module tb_grad_mag_l1;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_datay = '0;
    logic        i_DyValid = 1'b0;
    logic [31:0] i_datax = '0;
    logic        i_DxValid = 1'b0;
    logic [31:0] o_mag;
    logic        o_valid;
    logic [11:0] o_addr;
    logic [31:0] o_max;
    logic        o_done;
    logic        o_bussy;
    logic        o_err;

    always #5 clk = ~clk;

    grad_mag_l1 dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_datay(i_datay), .i_DyValid(i_DyValid),
        .i_datax(i_datax), .i_DxValid(i_DxValid),
        .o_mag(o_mag), .o_valid(o_valid), .o_addr(o_addr), .o_max(o_max),
        .o_done(o_done), .o_bussy(o_bussy), .o_err(o_err)
    );

    typedef struct {
        logic [31:0] mag;
        logic [11:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    bit          m_run = 1'b0;
    int          m_pix = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_max = '0;
    int          errors = 0;
    int          checks = 0;
    int          n_valid = 0;
    int          n_done = 0;
    exp_t        mon_e;

    function automatic longint mabs(input logic [31:0] v);
        longint x;
        x = {32'b0, v};
        if (v[31]) return 64'h1_0000_0000 - x;
        return x;
    endfunction

    // Monitor: compares every DUT result against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (o_done) n_done++;
        if (o_valid) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got mag=%h addr=%0d, required no output", o_mag, o_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_mag !== mon_e.mag || o_addr !== mon_e.addr) begin
                    errors++;
                    $display("FAIL result: got mag=%h addr=%0d, required mag=%h addr=%0d",
                             o_mag, o_addr, mon_e.mag, mon_e.addr);
                end
            end
        end
    end

    // Drive one cycle of stimulus at the falling edge and advance the model to match.
    task automatic drive(input logic start, input logic dyv, input logic [31:0] dy,
                         input logic dxv, input logic [31:0] dx);
        bit          empty, full, pop;
        logic [31:0] d;
        longint      s;
        exp_t        e;
        @(negedge clk);
        i_reset = 1'b0; i_start = start;
        i_DyValid = dyv; i_datay = dy; i_DxValid = dxv; i_datax = dx;
        if (m_run) begin
            empty = (mq.size() == 0);
            full  = (mq.size() == 128);
            pop   = dxv && !empty;
            if (pop) begin
                d = mq.pop_front();
                s = mabs(d) + mabs(dx);
                e.mag  = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
                e.addr = m_pix[11:0];
                exp_q.push_back(e);
                if (e.mag > m_max) m_max = e.mag;
                if (m_pix == 4095) m_run = 1'b0;
                m_pix++;
            end
            if (dxv && empty) m_err = 1'b1;
            if (dyv) begin
                if (!full || pop) mq.push_back(dy);
                else m_err = 1'b1;
            end
        end else if (start) begin
            m_run = 1'b1; mq.delete(); m_pix = 0; m_err = 1'b0; m_max = '0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        i_reset = 1'b1; i_start = 1'b0; i_DyValid = 1'b0; i_DxValid = 1'b0;
        m_run = 1'b0; mq.delete(); exp_q.delete(); m_err = 1'b0; m_max = '0; m_pix = 0;
    endtask

    task automatic check_all_zero(input string name);
        @(posedge clk); #1;
        checks++;
        if ({o_mag, o_valid, o_addr, o_max, o_done, o_bussy, o_err} !== '0) begin
            errors++;
            $display("FAIL %s: got mag=%h v=%b addr=%0d max=%h done=%b busy=%b err=%b, required all 0",
                     name, o_mag, o_valid, o_addr, o_max, o_done, o_bussy, o_err);
        end
    endtask

    task automatic test_reset;
        do_reset;
        check_all_zero("reset_state");
    endtask

    task automatic test_basic;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        @(posedge clk); #1;
        checks++;
        if (o_bussy !== 1'b1) begin errors++; $display("FAIL busy_run: got %b required 1", o_bussy); end
        drive(1'b0, 1'b1, 32'd5, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b1, -32'sd3);
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%b required 0", o_valid); end
        idle(1);
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b1 || o_mag !== 32'd8 || o_addr !== 12'd0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_pair: got v=%b mag=%0d addr=%0d err=%b, required v=1 mag=8 addr=0 err=0",
                     o_valid, o_mag, o_addr, o_err);
        end
    endtask

    task automatic test_saturate;
        // i_start in RUN must be ignored: addresses continue from 1.
        drive(1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
        drive(1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000);
        drive(1'b0, 1'b0, '0, 1'b1, 32'h7FFF_FFFF);
        idle(3);
        checks++;
        if (o_mag !== 32'hFFFF_FFFE || o_addr !== 12'd2) begin
            errors++;
            $display("FAIL sat_last: got mag=%h addr=%0d, required mag=fffffffe addr=2", o_mag, o_addr);
        end
        checks++;
        if (o_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_max: got %h required ffffffff", o_max); end
    endtask

    task automatic test_overflow;
        do_reset;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 128; i++) drive(1'b0, 1'b1, 32'(i * 3 - 100), 1'b0, '0);
        idle(1);
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL fill_128: got err=%b required 0", o_err); end
        drive(1'b0, 1'b1, 32'd77, 1'b1, 32'd1);
        idle(1);
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL push_pop_full: got err=%b required 0", o_err); end
        drive(1'b0, 1'b1, 32'd99, 1'b0, '0);
        idle(2);
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL overflow: got err=%b required 1", o_err); end
    endtask

    task automatic test_underflow;
        int v0;
        do_reset;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        v0 = n_valid;
        drive(1'b0, 1'b0, '0, 1'b1, 32'd7);
        idle(3);
        checks++;
        if (o_err !== 1'b1 || n_valid != v0) begin
            errors++;
            $display("FAIL underflow_empty: got err=%b outputs=%0d, required err=1 outputs=0", o_err, n_valid - v0);
        end
        do_reset;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b1, 32'd10, 1'b1, 32'd7);
        idle(3);
        checks++;
        if (o_err !== 1'b1 || n_valid != v0) begin
            errors++;
            $display("FAIL underflow_bypass: got err=%b outputs=%0d, required err=1 outputs=0", o_err, n_valid - v0);
        end
        drive(1'b0, 1'b0, '0, 1'b1, -32'sd4);
        idle(3);
        checks++;
        if (o_mag !== 32'd14 || o_addr !== 12'd0 || n_valid != v0 + 1) begin
            errors++;
            $display("FAIL underflow_no_advance: got mag=%0d addr=%0d outputs=%0d, required mag=14 addr=0 outputs=1",
                     o_mag, o_addr, n_valid - v0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i <= 2000; i++)
            drive(1'b0, i < 2000, $urandom, i > 0, $urandom);
        do_reset;
        check_all_zero("reset_mid_frame");
    endtask

    task automatic test_idle_ignore;
        int v0;
        v0 = n_valid;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'd1, 1'b1, 32'd1);
        idle(3);
        checks++;
        if (o_err !== 1'b0 || o_bussy !== 1'b0 || n_valid != v0) begin
            errors++;
            $display("FAIL idle_ignore: got err=%b busy=%b outputs=%0d, required 0 0 0",
                     o_err, o_bussy, n_valid - v0);
        end
    endtask

    task automatic test_back_to_back;
        int v0, d0, k;
        v0 = n_valid; d0 = n_done;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4096 + 68; i++)
            drive(1'b0, i < 4096, $urandom, i >= 68, $urandom);
        k = 0;
        while (n_done == d0 && k < 50) begin idle(1); k++; end
        checks++;
        if (n_done == d0) begin errors++; $display("FAIL done_timeout: got no done in 50 cycles, required 1 pulse"); end
        idle(4);
        checks++;
        if (n_valid - v0 != 4096 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_count: got %0d outputs (%0d pending), required 4096 (0 pending)",
                     n_valid - v0, exp_q.size());
        end
        checks++;
        if (n_done - d0 != 1) begin errors++; $display("FAIL done_once: got %0d pulses required 1", n_done - d0); end
        checks++;
        if (o_max !== m_max) begin errors++; $display("FAIL frame_max: got %h required %h", o_max, m_max); end
        checks++;
        if (o_bussy !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: got busy=%b err=%b required busy=0 err=0", o_bussy, o_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturate;
        test_overflow;
        test_underflow;
        test_reset_mid;
        test_idle_ignore;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
